// File: rtl/seq_detect_param_pkg.sv
// seq_detect_param_pkg
// Shared definitions for the programmable symbol-sequence detector:
// default parameter values, the mode encoding, the power-up pattern
// generator and the derived-width helpers used by the top-level ports.
package seq_detect_param_pkg;

    localparam int DEF_SYM_W   = 2;
    localparam int DEF_PAT_LEN = 3;
    localparam int DEF_CNT_W   = 8;

    typedef enum logic {
        MODE_STRICT = 1'b0,
        MODE_REPEAT = 1'b1
    } mode_e;

    // Default pattern element i is i+1; the caller truncates to the symbol
    // width, which gives the wrap-around modulo 2^SYM_W.
    function automatic int default_sym(input int i);
        return i + 1;
    endfunction

    // Index width never drops below one bit, even for a single-entry pattern.
    function automatic int calc_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Length field must be able to hold the value n itself.
    function automatic int calc_len_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_detect_param_sat.sv
// sat_counter
// Saturating up-counter with synchronous active-low reset.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous reset, active-low
//   clr   - synchronous clear, wins over inc
//   inc   - count one event (ignored once saturated)
//   cnt   - current count
//   sat   - count is all ones
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat
);

    assign sat = &cnt;

    // Clear outranks increment so a clear issued alongside an event
    // still leaves the counter at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// seq_detect_param
// Programmable symbol-sequence detector. Tracks how many elements of a
// runtime-programmed pattern have been seen (pos) and flags a match when the
// whole active length has been seen. Repeat mode lets each element repeat;
// strict mode does not. A saturating counter tallies matches.
// Ports:
//   clk, rst_n          - clock and synchronous active-low reset
//   in_valid, sym       - incoming symbol stream
//   mode_repeat         - 1 = repeat-tolerant, 0 = strict
//   cfg_we/idx/sym      - pattern entry write
//   cfg_len_we/cfg_len  - active pattern length write
//   clr_cnt             - clear the match counter
//   match               - level, high while the full pattern is held
//   match_pulse         - one cycle on entering the matched state
//   match_cnt, cnt_sat  - saturating match count and its saturation flag
module seq_detect_param
    import seq_detect_param_pkg::*;
#(
    parameter  int SYM_W   = DEF_SYM_W,
    parameter  int PAT_LEN = DEF_PAT_LEN,
    parameter  int CNT_W   = DEF_CNT_W,
    localparam int IDX_W   = calc_idx_w(PAT_LEN),
    localparam int LEN_W   = calc_len_w(PAT_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [SYM_W-1:0] sym,
    input  logic             mode_repeat,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [SYM_W-1:0] cfg_sym,
    input  logic             cfg_len_we,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             clr_cnt,
    output logic             match,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    logic [SYM_W-1:0] pat [PAT_LEN];
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] pos;
    logic [LEN_W-1:0] pos_next;
    logic [SYM_W-1:0] pat_cur;
    logic [SYM_W-1:0] pat_prev;
    logic             idx_ok;
    logic             len_ok;
    logic             cfg_accept;
    logic             hit;

    // The index is widened by one bit so PAT_LEN itself is representable
    // when PAT_LEN is a power of two.
    assign idx_ok     = cfg_we && ({1'b0, cfg_idx} < (IDX_W + 1)'(PAT_LEN));
    assign len_ok     = cfg_len_we && (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_LEN));
    assign cfg_accept = idx_ok || len_ok;

    // Select the element expected next and the one just matched without
    // ever indexing past the pattern array.
    always_comb begin
        pat_cur  = '0;
        pat_prev = '0;
        for (int i = 0; i < PAT_LEN; i++) begin
            if (pos == LEN_W'(i)) begin
                pat_cur = pat[i];
            end
            if (pos == LEN_W'(i + 1)) begin
                pat_prev = pat[i];
            end
        end
    end

    // Next-state: an accepted config write restarts the search and drops the
    // symbol presented with it. Otherwise advance, hold on a repeated element
    // (repeat mode only), restart on the first element, or fall back to zero.
    always_comb begin
        pos_next = pos;
        if (cfg_accept) begin
            pos_next = '0;
        end else if (in_valid) begin
            if ((pos < len) && (sym == pat_cur)) begin
                pos_next = pos + LEN_W'(1);
            end else if ((mode_e'(mode_repeat) == MODE_REPEAT) &&
                         (pos != '0) && (sym == pat_prev)) begin
                pos_next = pos;
            end else if (sym == pat[0]) begin
                pos_next = LEN_W'(1);
            end else begin
                pos_next = '0;
            end
        end
    end

    // A match event is an entry into the full state, never a stay in it.
    assign hit   = (pos_next == len) && (pos != len);
    assign match = (pos == len);

    // Position, pattern and length registers; reset restores the default
    // pattern and full length.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos         <= '0;
            len         <= LEN_W'(PAT_LEN);
            match_pulse <= 1'b0;
            for (int i = 0; i < PAT_LEN; i++) begin
                pat[i] <= SYM_W'(default_sym(i));
            end
        end else begin
            pos         <= pos_next;
            match_pulse <= hit;
            if (len_ok) begin
                len <= cfg_len;
            end
            for (int i = 0; i < PAT_LEN; i++) begin
                if (idx_ok && (cfg_idx == IDX_W'(i))) begin
                    pat[i] <= cfg_sym;
                end
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_cnt),
        .inc   (hit),
        .cnt   (match_cnt),
        .sat   (cnt_sat)
    );

endmodule
